// File: rtl/uart_apb_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_apb_sequencer_if
// Brief   : APB3 master bus plus TX/RX byte streams of the UART sequencer.
// Revision: 1.0
// ============================================================================
interface uart_apb_sequencer_if;
    logic [4:0] M_PADDR;
    logic       M_PSEL;
    logic       M_PENABLE;
    logic       M_PWRITE;
    logic [7:0] M_PWDATA;
    logic [7:0] M_PRDATA;
    logic       M_PREADY;
    logic       M_PSLVERR;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (
        output M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
        input  M_PRDATA, M_PREADY, M_PSLVERR,
        input  tx_valid, tx_data,
        output tx_ready,
        output rx_valid, rx_data,
        input  rx_ready
    );

    modport slave (
        input  M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
        output M_PRDATA, M_PREADY, M_PSLVERR,
        output tx_valid, tx_data,
        input  tx_ready,
        input  rx_valid, rx_data,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : uart_apb_sequencer
// Brief   : APB3 master that configures a CoreUARTapb and moves TX/RX bytes.
// Revision: 1.0
// ============================================================================
module uart_apb_sequencer #(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter logic        BIT8       = 1'b1,
    parameter logic        PARITY_EN  = 1'b0,
    parameter logic        ODD_N_EVEN = 1'b0
) (
    input  logic                        PCLK,
    input  logic                        PRESETN,
    uart_apb_sequencer_if.master        bus,
    output logic [3:0]                  err,
    input  logic                        err_clr,
    output logic                        cfg_done
);
    localparam logic [4:0] c_ADDR_TXDATA = 5'h00;
    localparam logic [4:0] c_ADDR_RXDATA = 5'h04;
    localparam logic [4:0] c_ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] c_ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] c_ADDR_STATUS = 5'h10;
    localparam logic [7:0] c_CTRL1_VAL   = BAUD_VALUE[7:0];
    localparam logic [7:0] c_CTRL2_VAL   = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};

    typedef enum logic [2:0] {
        S_CFG1   = 3'd0,
        S_CFG2   = 3'd1,
        S_POLL   = 3'd2,
        S_DECIDE = 3'd3,
        S_TXWR   = 3'd4,
        S_RXRD   = 3'd5,
        S_GAP    = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_run;
    logic       r_access;
    logic       r_last_tx;
    logic [1:0] r_status;
    logic [7:0] r_tx_byte;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic [3:0] r_err;
    logic [3:0] w_err_next;
    logic       r_cfg_done;

    logic       w_bus_state;
    logic       w_psel;
    logic       w_done;
    logic       w_write;
    logic [4:0] w_addr;
    logic [7:0] w_wdata;
    logic       w_tx_elig;
    logic       w_rx_elig;
    logic       w_pick_tx;
    logic       w_pick_rx;

    // Per-state APB request; address/data are held constant for the whole access.
    always_comb begin
        w_bus_state = 1'b0;
        w_addr      = '0;
        w_write     = 1'b0;
        w_wdata     = '0;
        case (r_state)
            S_CFG1: begin
                w_bus_state = 1'b1;
                w_addr      = c_ADDR_CTRL1;
                w_write     = 1'b1;
                w_wdata     = c_CTRL1_VAL;
            end
            S_CFG2: begin
                w_bus_state = 1'b1;
                w_addr      = c_ADDR_CTRL2;
                w_write     = 1'b1;
                w_wdata     = c_CTRL2_VAL;
            end
            S_POLL: begin
                w_bus_state = 1'b1;
                w_addr      = c_ADDR_STATUS;
            end
            S_TXWR: begin
                w_bus_state = 1'b1;
                w_addr      = c_ADDR_TXDATA;
                w_write     = 1'b1;
                w_wdata     = r_tx_byte;
            end
            S_RXRD: begin
                w_bus_state = 1'b1;
                w_addr      = c_ADDR_RXDATA;
            end
            default: ;
        endcase
    end

    // r_run holds the bus quiet until the first clock after reset release.
    assign w_psel    = r_run & w_bus_state;
    assign w_done    = w_psel & r_access & bus.M_PREADY;
    assign w_tx_elig = r_status[0] & bus.tx_valid;
    assign w_rx_elig = r_status[1] & ~r_rx_valid;

    always_comb begin
        w_next    = r_state;
        w_pick_tx = 1'b0;
        w_pick_rx = 1'b0;
        case (r_state)
            S_CFG1:   if (w_done) w_next = S_CFG2;
            S_CFG2:   if (w_done) w_next = S_POLL;
            S_POLL:   if (w_done) w_next = S_DECIDE;
            S_DECIDE: begin
                if (w_tx_elig && (!w_rx_elig || !r_last_tx)) begin
                    w_pick_tx = 1'b1;
                    w_next    = S_TXWR;
                end else if (w_rx_elig) begin
                    w_pick_rx = 1'b1;
                    w_next    = S_RXRD;
                end else begin
                    w_next    = S_POLL;
                end
            end
            S_TXWR:   if (w_done) w_next = S_GAP;
            S_RXRD:   if (w_done) w_next = S_GAP;
            S_GAP:    w_next = S_POLL;
            default:  w_next = S_CFG1;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state  <= S_CFG1;
            r_run    <= 1'b0;
            r_access <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_run    <= 1'b1;
            r_access <= w_psel & ~w_done;
        end
    end

    // Clear first, then OR in new flags so a same-cycle set survives err_clr.
    always_comb begin
        w_err_next = err_clr ? 4'b0000 : r_err;
        if (w_done && (r_state == S_POLL)) begin
            w_err_next[0] = w_err_next[0] | bus.M_PRDATA[2];
            w_err_next[2] = w_err_next[2] | bus.M_PRDATA[3];
            w_err_next[1] = w_err_next[1] | bus.M_PRDATA[4];
        end
        if (w_done && bus.M_PSLVERR) begin
            w_err_next[3] = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_status   <= '0;
            r_tx_byte  <= '0;
            r_last_tx  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_err      <= '0;
            r_cfg_done <= 1'b0;
        end else begin
            r_err <= w_err_next;
            if (w_done && (r_state == S_POLL)) begin
                r_status <= bus.M_PRDATA[1:0];
            end
            if (w_pick_tx) begin
                r_tx_byte <= bus.tx_data;
                r_last_tx <= 1'b1;
            end else if (w_pick_rx) begin
                r_last_tx <= 1'b0;
            end
            if (w_done && (r_state == S_RXRD)) begin
                r_rx_data  <= bus.M_PRDATA;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_done && (r_state == S_CFG2)) begin
                r_cfg_done <= 1'b1;
            end
        end
    end

    assign bus.M_PSEL    = w_psel;
    assign bus.M_PENABLE = w_psel & r_access;
    assign bus.M_PADDR   = w_psel ? w_addr : 5'h00;
    assign bus.M_PWRITE  = w_psel & w_write;
    assign bus.M_PWDATA  = w_psel ? w_wdata : 8'h00;
    assign bus.tx_ready  = w_pick_tx;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.rx_data   = r_rx_data;
    assign err           = r_err;
    assign cfg_done      = r_cfg_done;
endmodule
`default_nettype wire
